// File: rtl/mem_stage_if.sv
// ============================================================================
// Module      : mem_stage_if
// Description : EX/MEM slot contents and data-memory return bus feeding the
//               memory stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_stage_if;
  logic        mem_valid;
  logic [29:0] mem_pcp1;
  logic [4:0]  mem_rw;
  logic [31:0] mem_exout;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic        mem_isbyte;
  logic        mem_ishalf;
  logic        mem_signed;
  logic [31:0] dm_word;
  logic        dm_ready;

  modport master (
    output mem_valid, mem_pcp1, mem_rw, mem_exout, mem_regwrite, mem_memtoreg,
           mem_isbyte, mem_ishalf, mem_signed, dm_word, dm_ready
  );

  modport slave (
    input  mem_valid, mem_pcp1, mem_rw, mem_exout, mem_regwrite, mem_memtoreg,
           mem_isbyte, mem_ishalf, mem_signed, dm_word, dm_ready
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage: load alignment, ready-wait FSM with
//               timeout, MEM-resolved branch correction, MEM/WB register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mem_stage_if.slave       ex,
  input  wire logic [2:0]  br_type,
  input  wire logic        br_at_mem,
  input  wire logic        br_predict,
  input  wire logic        br_taken,
  input  wire logic [31:0] br_bpc,
  input  wire logic [31:0] br_nojpc,
  input  wire logic        mem_flush,
  output logic             stall_req,
  output logic             bus_err,
  output logic             correct_at_mem,
  output logic [31:0]      correct_pc,
  output logic [37:0]      mem_back,
  output logic             wb_regwrite,
  output logic [4:0]       wb_rw,
  output logic [31:0]      wb_data,
  output logic [29:0]      wb_pcp1
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        abort;
  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extracted;
  logic [31:0] value;

  assign off      = ex.mem_exout[1:0];
  assign half_sel = off[1] ? ex.dm_word[31:16] : ex.dm_word[15:0];

  always_comb begin
    byte_sel = ex.dm_word[7:0];
    case (off)
      2'd1:    byte_sel = ex.dm_word[15:8];
      2'd2:    byte_sel = ex.dm_word[23:16];
      2'd3:    byte_sel = ex.dm_word[31:24];
      default: byte_sel = ex.dm_word[7:0];
    endcase
  end

  always_comb begin
    extracted = ex.dm_word;
    if (ex.mem_isbyte)
      extracted = {{24{ex.mem_signed & byte_sel[7]}}, byte_sel};
    else if (ex.mem_ishalf)
      extracted = {{16{ex.mem_signed & half_sel[15]}}, half_sel};
  end

  assign value    = ex.mem_memtoreg ? extracted : ex.mem_exout;
  assign mem_back = {ex.mem_valid & ex.mem_regwrite & ~stall_req, ex.mem_rw, value};

  assign correct_at_mem = ex.mem_valid & br_at_mem & (br_type != 3'd0) &
                          (br_predict != br_taken);
  assign correct_pc     = br_taken ? br_bpc : br_nojpc;

  // abort marks the cycle the waiting load is abandoned; its write is squashed
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_req = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ex.mem_valid & ex.mem_memtoreg & ~ex.dm_ready) begin
          stall_req = 1'b1;
          state_nxt = S_WAIT;
          cnt_nxt   = 8'd1;
        end
      end
      S_WAIT: begin
        stall_req = ~ex.dm_ready & (cnt < TMO);
        if (ex.dm_ready) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
        end else if (cnt >= TMO) begin
          state_nxt = S_ERR;
          cnt_nxt   = 8'd0;
          abort     = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_ERR: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      bus_err     <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rw       <= 5'd0;
      wb_data     <= 32'd0;
      wb_pcp1     <= 30'd0;
    end else if (mem_flush) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      bus_err     <= 1'b0;
      wb_regwrite <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bus_err <= abort;
      if (stall_req) begin
        wb_regwrite <= 1'b0;
      end else if (abort || state == S_ERR) begin
        wb_regwrite <= 1'b0;
        wb_rw       <= ex.mem_rw;
        wb_data     <= 32'd0;
        wb_pcp1     <= ex.mem_pcp1;
      end else begin
        wb_regwrite <= ex.mem_valid & ex.mem_regwrite;
        wb_rw       <= ex.mem_rw;
        wb_data     <= value;
        wb_pcp1     <= ex.mem_pcp1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline. It sits directly downstream of the execute stage and consumes the EX/MEM register contents plus the raw data-memory word returned by the access unit.
- Performs load-data alignment and extension, waits on the data-memory ready handshake, and resolves branches committed at MEM.
- Drives the MEM bypass path and registers results into MEM/WB.

Parameters:
TIMEOUT, 15, maximum cycles spent in WAIT before a load is abandoned as a bus error (1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
mem_valid  in  1  EX/MEM slot holds a live instruction
mem_pcp1  in  30  PC+4 word address (PC[31:2]+1)
mem_rw  in  5  destination register
mem_exout  in  32  EX result; bits [1:0] are the access byte offset for loads
mem_regwrite  in  1  WB control: write register
mem_memtoreg  in  1  WB control: result comes from memory
mem_isbyte  in  1  byte access
mem_ishalf  in  1  halfword access
mem_signed  in  1  sign-extend loaded byte/half
dm_word  in  32  raw aligned data-memory word
dm_ready  in  1  data memory has valid dm_word this cycle
br_type  in  3  branch type (0 = none)
br_at_mem  in  1  branch resolves at MEM
br_predict  in  1  predicted taken
br_taken  in  1  actual outcome computed in EX
br_bpc  in  32  taken target
br_nojpc  in  32  fall-through target
mem_flush  in  1  controller flush of MEM/WB
stall_req  out  1  hold IF..EX/MEM while a load waits
bus_err  out  1  one-cycle pulse on load timeout
correct_at_mem  out  1  branch misprediction detected at MEM
correct_pc  out  32  redirect PC
mem_back  out  38  bypass {regwrite, rw[4:0], value[31:0]}
wb_regwrite  out  1  MEM/WB regwrite
wb_rw  out  5  MEM/WB destination
wb_data  out  32  MEM/WB write data
wb_pcp1  out  30  MEM/WB PC+4

Behaviour:
- Reset (rst=0, asynchronous): every registered output is 0; FSM enters IDLE; wait counter is 0.
- Load extract (combinational), with off = mem_exout[1:0]:
  - Byte: select dm_word[8*off+7:8*off].
  - Half: select dm_word[31:16] if off[1] else dm_word[15:0]; off[0] is ignored.
  - Word: dm_word unchanged.
  - Byte/half results are sign-extended when mem_signed=1, zero-extended otherwise.
- value = mem_memtoreg ? extracted : mem_exout.
- mem_back = {mem_valid & mem_regwrite & !stall_req, mem_rw, value}. The regwrite bit is 0 while the load is still waiting.
- Branch correction (combinational):
  - correct_at_mem = mem_valid & br_at_mem & (br_type!=0) & (br_predict!=br_taken).
  - correct_pc = br_taken ? br_bpc : br_nojpc. correct_pc is valid regardless of correct_at_mem.
- Load-wait FSM:
  - IDLE: when mem_valid & mem_memtoreg & !dm_ready, stall_req=1 (combinational) and go to WAIT with cnt=1. Otherwise stay in IDLE with stall_req=0.
  - WAIT: stall_req = !dm_ready & (cnt<TIMEOUT).
    - dm_ready=1: return to IDLE; the result is written this cycle.
    - cnt==TIMEOUT and !dm_ready: go to ERR.
    - Otherwise cnt increments.
  - ERR: a single cycle. bus_err=1 (registered), stall_req=0, the MEM/WB write uses data 0 with regwrite=0, then return to IDLE.
  - Load latency: 0 extra cycles if dm_ready is already high in IDLE; otherwise N extra cycles, where N is the number of cycles dm_ready stays low.
- MEM/WB register, on posedge clk, evaluated in priority order:
  - mem_flush: wb_regwrite=0 and FSM forced to IDLE. Flush wins over a pending wait and over ERR; bus_err is suppressed.
  - stall_req=1: insert a bubble (wb_regwrite=0); wb_rw, wb_data and wb_pcp1 hold their previous values.
  - Otherwise: wb_regwrite=mem_valid & mem_regwrite, wb_rw=mem_rw, wb_data=value, wb_pcp1=mem_pcp1.
- Stores and non-memory instructions never enter WAIT.
- A reset asserted mid-WAIT clears the FSM, counter and outputs immediately.

Test Plan:
- Signed byte load: dm_word=32'h80FF_7F01, off=3, mem_signed=1, dm_ready=1 -> next cycle wb_data=32'hFFFF_FF80, wb_regwrite=1, stall_req never rises.
- Unsigned half load: same dm_word, off=2, mem_signed=0 -> wb_data=32'h0000_80FF.
- Load with dm_ready low for 3 cycles -> stall_req high for exactly 3 cycles, 3 bubbles (wb_regwrite=0), then the correct data lands in the next MEM/WB update; mem_back regwrite bit stays 0 until ready.
- TIMEOUT=4 with dm_ready held low -> stall_req high 4 cycles, then bus_err pulses for 1 cycle, wb_regwrite=0, FSM back in IDLE.
- br_at_mem=1, br_type=1, br_predict=0, br_taken=1, br_bpc=32'h0040_0100 -> correct_at_mem=1, correct_pc=32'h0040_0100. With br_at_mem=0 -> correct_at_mem=0.
- mem_flush asserted on the cycle WAIT would time out -> no bus_err, wb_regwrite=0, FSM returns to IDLE. Separately, rst pulsed low mid-WAIT -> all outputs 0 asynchronously.
